// File: rtl/qea_pkg.sv
// Shared FSM type, default widths and fixed-point helpers for the QEA job loader.
package qea_pkg;

  localparam int DEF_PE_NUM_WIDTH            = 2;
  localparam int DEF_PE_NUM                  = 4;
  localparam int DEF_DATA_WIDTH              = 32;
  localparam int DEF_STATE_DATA_WIDTH        = 64;
  localparam int DEF_STATE_ADDR_WIDTH        = 16;
  localparam int DEF_GATE_CONTEXT_DATA_WIDTH = 64;
  localparam int DEF_GATE_CONTEXT_ADDR_WIDTH = 16;
  localparam int DEF_MAX_QBIT_WIDTH          = 6;
  localparam int DEF_NUM_FRAC_BIT            = 30;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_CTX   = 3'd1,
    INIT_STATE = 3'd2,
    START      = 3'd3,
    WAIT       = 3'd4,
    DONE       = 3'd5
  } qea_state_t;

  function automatic logic [DEF_DATA_WIDTH-1:0] qea_one(input int num_frac_bit);
    return {{(DEF_DATA_WIDTH-1){1'b0}}, 1'b1} << num_frac_bit;
  endfunction

  // Number of state RAM words holding 2^qbit_num amplitudes spread over the PE lanes.
  function automatic logic [DEF_STATE_ADDR_WIDTH:0] qea_state_words(
    input logic [DEF_MAX_QBIT_WIDTH-1:0] qbit_num,
    input int                            pe_num_width
  );
    return {{DEF_STATE_ADDR_WIDTH{1'b0}}, 1'b1} << (int'(qbit_num) - pe_num_width);
  endfunction

endpackage

// File: rtl/qea_job_loader_if.sv
// Job submission handshakes: header (cfg) channel and gate-context (ctx) beat stream.
interface qea_job_loader_if import qea_pkg::*; #(
  parameter int MAX_QBIT_WIDTH          = DEF_MAX_QBIT_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = DEF_GATE_CONTEXT_ADDR_WIDTH,
  parameter int GATE_CONTEXT_DATA_WIDTH = DEF_GATE_CONTEXT_DATA_WIDTH
);
  logic                               i_cfg_valid;
  logic                               o_cfg_ready;
  logic [MAX_QBIT_WIDTH-1:0]          i_cfg_qbit_num;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_cfg_ins_num;
  logic                               i_ctx_valid;
  logic                               o_ctx_ready;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data;

  modport master (
    output i_cfg_valid, i_cfg_qbit_num, i_cfg_ins_num, i_ctx_valid, i_ctx_data,
    input  o_cfg_ready, o_ctx_ready
  );

  modport slave (
    input  i_cfg_valid, i_cfg_qbit_num, i_cfg_ins_num, i_ctx_valid, i_ctx_data,
    output o_cfg_ready, o_ctx_ready
  );
endinterface

// File: rtl/qea_state_init_gen.sv
// Streams the |0...0> state image into the state RAM: one word per cycle while enabled.
module qea_state_init_gen import qea_pkg::*; #(
  parameter int PE_NUM           = DEF_PE_NUM,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int STATE_DATA_WIDTH = DEF_STATE_DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH = DEF_STATE_ADDR_WIDTH,
  parameter int NUM_FRAC_BIT     = DEF_NUM_FRAC_BIT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [STATE_ADDR_WIDTH:0]          n_words,
  output logic                               last,
  output logic                               ena,
  output logic                               wea,
  output logic [STATE_ADDR_WIDTH-1:0]        addr,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] data
);
  localparam int W = PE_NUM * STATE_DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ONE_FX = DATA_WIDTH'(qea_one(NUM_FRAC_BIT));
  // Amplitude 1.0 (real part) sits in the top lane of word 0.
  localparam logic [W-1:0] WORD0 = {ONE_FX, {(W-DATA_WIDTH){1'b0}}};
  localparam logic [STATE_ADDR_WIDTH:0] CNT_ONE = (STATE_ADDR_WIDTH+1)'(1);

  logic [STATE_ADDR_WIDTH:0] cnt_r;

  assign last = en && (cnt_r == (n_words - CNT_ONE));

  // Word counter plus registered write strobe/address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      ena   <= 1'b0;
      wea   <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (en) begin
      ena   <= 1'b1;
      wea   <= 1'b1;
      addr  <= cnt_r[STATE_ADDR_WIDTH-1:0];
      data  <= (cnt_r == '0) ? WORD0 : '0;
      cnt_r <= last ? '0 : (cnt_r + CNT_ONE);
    end else begin
      ena   <= 1'b0;
      wea   <= 1'b0;
      cnt_r <= '0;
    end
  end
endmodule

// File: rtl/qea_job_loader.sv
// QEA job loader: header accept, context RAM load, state RAM init, start and completion wait.
// Optional QEA_JOB_LOADER_CYCLE_CNT_EN adds o_exec_cycles (WAIT-cycle count of the last job).
module qea_job_loader import qea_pkg::*; #(
  parameter int PE_NUM_WIDTH            = DEF_PE_NUM_WIDTH,
  parameter int PE_NUM                  = DEF_PE_NUM,
  parameter int DATA_WIDTH              = DEF_DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = DEF_STATE_DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = DEF_STATE_ADDR_WIDTH,
  parameter int GATE_CONTEXT_DATA_WIDTH = DEF_GATE_CONTEXT_DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = DEF_GATE_CONTEXT_ADDR_WIDTH,
  parameter int MAX_QBIT_WIDTH          = DEF_MAX_QBIT_WIDTH,
  parameter int NUM_FRAC_BIT            = DEF_NUM_FRAC_BIT
) (
  input  logic                               clk,
  input  logic                               rst,
  qea_job_loader_if.slave                    bus,
  output logic                               o_ctx_en,
  output logic                               o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
  output logic                               o_state_ena,
  output logic                               o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dina,
  output logic                               o_start,
  output logic [MAX_QBIT_WIDTH-1:0]          o_qbit_num,
  input  logic                               i_complete,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err
`ifdef QEA_JOB_LOADER_CYCLE_CNT_EN
  ,
  output logic [31:0]                        o_exec_cycles
`endif
);
  localparam logic [MAX_QBIT_WIDTH-1:0] MIN_QBIT = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] MAX_QBIT = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  localparam logic [GATE_CONTEXT_ADDR_WIDTH:0] CTX_ONE = (GATE_CONTEXT_ADDR_WIDTH+1)'(1);

  qea_state_t                         state_r;
  logic                               cfg_ready_r;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_num_r;
  logic [GATE_CONTEXT_ADDR_WIDTH:0]   ctx_cnt_r;
  logic [STATE_ADDR_WIDTH:0]          n_words_r;
  logic                               wait_first_r;
  logic                               cfg_ok_s;
  logic                               cfg_fire_s;
  logic                               ctx_fire_s;
  logic                               init_last_s;

  assign bus.o_cfg_ready = cfg_ready_r;
  // Ready falls combinationally once the final beat has been counted.
  assign bus.o_ctx_ready = (state_r == LOAD_CTX) && (ctx_cnt_r < {1'b0, ins_num_r});
  assign cfg_fire_s      = bus.i_cfg_valid & cfg_ready_r;
  assign ctx_fire_s      = bus.i_ctx_valid & bus.o_ctx_ready;

  // Header legality: non-empty program and a state image that fits the state RAM.
  always_comb begin
    if (bus.i_cfg_ins_num == '0) begin
      cfg_ok_s = 1'b0;
    end else if (bus.i_cfg_qbit_num <= MIN_QBIT) begin
      cfg_ok_s = 1'b0;
    end else if (bus.i_cfg_qbit_num > MAX_QBIT) begin
      cfg_ok_s = 1'b0;
    end else begin
      cfg_ok_s = 1'b1;
    end
  end

  // Job sequencing FSM with registered handshake and context write outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cfg_ready_r  <= 1'b0;
      ins_num_r    <= '0;
      ctx_cnt_r    <= '0;
      n_words_r    <= '0;
      wait_first_r <= 1'b0;
      o_ctx_en     <= 1'b0;
      o_ctx_wea    <= 1'b0;
      o_ctx_addr   <= '0;
      o_ctx_data   <= '0;
      o_start      <= 1'b0;
      o_qbit_num   <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_ctx_en  <= 1'b0;
      o_ctx_wea <= 1'b0;
      o_start   <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      case (state_r)
        IDLE: begin
          cfg_ready_r <= 1'b1;
          if (cfg_fire_s) begin
            o_qbit_num <= bus.i_cfg_qbit_num;
            ins_num_r  <= bus.i_cfg_ins_num;
            if (cfg_ok_s) begin
              state_r     <= LOAD_CTX;
              cfg_ready_r <= 1'b0;
              o_busy      <= 1'b1;
              ctx_cnt_r   <= '0;
              n_words_r   <= qea_state_words(bus.i_cfg_qbit_num, PE_NUM_WIDTH);
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        LOAD_CTX: begin
          if (ctx_fire_s) begin
            o_ctx_en   <= 1'b1;
            o_ctx_wea  <= 1'b1;
            o_ctx_addr <= ctx_cnt_r[GATE_CONTEXT_ADDR_WIDTH-1:0];
            o_ctx_data <= bus.i_ctx_data;
            ctx_cnt_r  <= ctx_cnt_r + CTX_ONE;
            if ((ctx_cnt_r + CTX_ONE) == {1'b0, ins_num_r}) begin
              state_r <= INIT_STATE;
            end
          end
        end
        INIT_STATE: begin
          if (init_last_s) begin
            state_r <= START;
          end
        end
        START: begin
          o_start      <= 1'b1;
          wait_first_r <= 1'b1;
          state_r      <= WAIT;
        end
        WAIT: begin
          // The first WAIT cycle ignores a completion level left over from the last job.
          wait_first_r <= 1'b0;
          if (!wait_first_r && i_complete) begin
            state_r <= DONE;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          cfg_ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  qea_state_init_gen #(
    .PE_NUM           (PE_NUM),
    .DATA_WIDTH       (DATA_WIDTH),
    .STATE_DATA_WIDTH (STATE_DATA_WIDTH),
    .STATE_ADDR_WIDTH (STATE_ADDR_WIDTH),
    .NUM_FRAC_BIT     (NUM_FRAC_BIT)
  ) u_state_init (
    .clk     (clk),
    .rst     (rst),
    .en      (state_r == INIT_STATE),
    .n_words (n_words_r),
    .last    (init_last_s),
    .ena     (o_state_ena),
    .wea     (o_state_wea),
    .addr    (o_state_addra),
    .data    (o_state_dina)
  );

`ifdef QEA_JOB_LOADER_CYCLE_CNT_EN
  logic [31:0] exec_cycles_r;
  assign o_exec_cycles = exec_cycles_r;

  // Saturating WAIT-cycle counter, cleared as start is issued and frozen outside WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_cycles_r <= 32'd0;
    end else if (state_r == START) begin
      exec_cycles_r <= 32'd0;
    end else if ((state_r == WAIT) && (exec_cycles_r != 32'hFFFF_FFFF)) begin
      exec_cycles_r <= exec_cycles_r + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_qea_job_loader.sv
// Scoreboard bench for qea_job_loader: directed jobs, rejects, stale completion and mid-job reset.
module tb_qea_job_loader;
  import qea_pkg::*;

  localparam logic [255:0] WORD0 = {32'h4000_0000, 224'h0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         i_complete;
  logic         o_ctx_en, o_ctx_wea;
  logic [15:0]  o_ctx_addr;
  logic [63:0]  o_ctx_data;
  logic         o_state_ena, o_state_wea;
  logic [15:0]  o_state_addra;
  logic [255:0] o_state_dina;
  logic         o_start;
  logic [5:0]   o_qbit_num;
  logic         o_busy, o_done, o_err;
`ifdef QEA_JOB_LOADER_CYCLE_CNT_EN
  logic [31:0]  o_exec_cycles;
`endif

  qea_job_loader_if bus ();

  qea_job_loader dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .o_ctx_en      (o_ctx_en),
    .o_ctx_wea     (o_ctx_wea),
    .o_ctx_addr    (o_ctx_addr),
    .o_ctx_data    (o_ctx_data),
    .o_state_ena   (o_state_ena),
    .o_state_wea   (o_state_wea),
    .o_state_addra (o_state_addra),
    .o_state_dina  (o_state_dina),
    .o_start       (o_start),
    .o_qbit_num    (o_qbit_num),
    .i_complete    (i_complete),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err)
`ifdef QEA_JOB_LOADER_CYCLE_CNT_EN
    ,
    .o_exec_cycles (o_exec_cycles)
`endif
  );

  typedef struct { logic [15:0] addr; logic [63:0]  data; } ctx_t;
  typedef struct { logic [15:0] addr; logic [255:0] data; } st_t;

  ctx_t ctx_q[$];
  st_t  st_q[$];
  int   err_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic prev_ctx_en = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000 ^ 32'(i), ~32'(i)};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT strobes a RAM write or an error.
  always @(negedge clk) begin
    if (o_ctx_en) begin
      if (ctx_q.size() == 0) begin
        check("ctx_unexpected", o_ctx_en, 1'b0);
      end else begin
        ctx_t e;
        e = ctx_q.pop_front();
        check("ctx_addr", o_ctx_addr, e.addr);
        check("ctx_data", o_ctx_data, e.data);
        check("ctx_wea", o_ctx_wea, 1'b1);
      end
    end
    if (o_state_ena) begin
      if (st_q.size() == 0) begin
        check("state_unexpected", o_state_ena, 1'b0);
      end else begin
        st_t s;
        s = st_q.pop_front();
        check("state_addr", o_state_addra, s.addr);
        check("state_data", o_state_dina, s.data);
        check("state_wea", o_state_wea, 1'b1);
        if (s.addr == 16'd0) check("state_follows_ctx", prev_ctx_en, 1'b1);
      end
    end
    if (o_err) begin
      if (err_q.size() == 0) begin
        check("err_unexpected", o_err, 1'b0);
      end else begin
        void'(err_q.pop_front());
        check("err_busy", o_busy, 1'b0);
      end
    end
    prev_ctx_en <= o_ctx_en;
  end

  task automatic check_zero(input string tag);
    check({tag, "_dina"}, o_state_dina, 256'h0);
    check({tag, "_outs"}, {bus.o_cfg_ready, bus.o_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr,
                           o_ctx_data, o_state_ena, o_state_wea, o_state_addra, o_start,
                           o_qbit_num, o_busy, o_done, o_err}, 512'h0);
`ifdef QEA_JOB_LOADER_CYCLE_CNT_EN
    check({tag, "_exec"}, o_exec_cycles, 32'd0);
`endif
  endtask

  task automatic send_header(input int qbit, input int ins, output bit ok);
    int g;
    g  = 0;
    ok = 1'b0;
    @(negedge clk);
    while (!bus.o_cfg_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.o_cfg_ready) begin
      check("cfg_ready_timeout", bus.o_cfg_ready, 1'b1);
      return;
    end
    bus.i_cfg_valid    = 1'b1;
    bus.i_cfg_qbit_num = qbit[5:0];
    bus.i_cfg_ins_num  = ins[15:0];
    @(posedge clk);
    #1;
    bus.i_cfg_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic bad_header(input int qbit, input int ins);
    bit ok;
    err_q.push_back(1);
    send_header(qbit, ins, ok);
    if (ok) begin
      @(negedge clk);
      check("err_pulse", o_err, 1'b1);
      check("err_stays_idle", bus.o_cfg_ready, 1'b1);
      @(negedge clk);
      check("err_one_cycle", o_err, 1'b0);
      check("err_not_busy", o_busy, 1'b0);
    end
  endtask

  // Header plus context stream; state expectations are queued once the header is taken.
  task automatic load_job(input int qbit, input int ins, input int nwords, input bit gap, output bit ok);
    int idx, cyc;
    bit acc_prev;
    send_header(qbit, ins, ok);
    if (!ok) return;
    for (int w = 0; w < nwords; w++) begin
      st_t s;
      s.addr = w[15:0];
      s.data = (w == 0) ? WORD0 : 256'h0;
      st_q.push_back(s);
    end
    idx = 0;
    cyc = 0;
    acc_prev = 1'b0;
    while (idx < ins && cyc < 20000) begin
      bus.i_ctx_valid = gap ? (cyc % 2 == 0) : 1'b1;
      bus.i_ctx_data  = pat(idx);
      @(negedge clk);
      check("ctx_strobe_latency", o_ctx_en, acc_prev);
      acc_prev = bus.i_ctx_valid && bus.o_ctx_ready;
      if (acc_prev) begin
        ctx_t e;
        e.addr = idx[15:0];
        e.data = pat(idx);
        ctx_q.push_back(e);
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.i_ctx_valid = 1'b0;
    if (idx < ins) check("ctx_timeout", idx, ins);
    @(negedge clk);
    check("ctx_strobe_latency", o_ctx_en, acc_prev);
    check("ctx_ready_drop", bus.o_ctx_ready, 1'b0);
  endtask

  // cw = WAIT cycle in which i_complete is first sampled high (fresh completion).
  task automatic finish_job(input int qbit, input int cw, input bit stale);
    int g;
    int exp_exec;
    g = 0;
    while (!o_start && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("start_seen", o_start, 1'b1);
    if (!o_start) return;
    check("qbit_latched", o_qbit_num, qbit[5:0]);
    check("busy_running", o_busy, 1'b1);
    check("state_writes_drained", st_q.size(), 0);
    @(negedge clk);
    check("start_one_cycle", o_start, 1'b0);
    check("done_masked_first_wait", o_done, 1'b0);
    if (stale) begin
      exp_exec = 2;
      @(negedge clk);
      check("done_pulse", o_done, 1'b1);
    end else begin
      exp_exec = cw;
      repeat (cw - 2) @(posedge clk);
      #1;
      i_complete = 1'b1;
      @(negedge clk);
      check("done_early", o_done, 1'b0);
      @(negedge clk);
      check("done_pulse", o_done, 1'b1);
    end
    check("busy_clear", o_busy, 1'b0);
`ifdef QEA_JOB_LOADER_CYCLE_CNT_EN
    check("exec_cycles", o_exec_cycles, exp_exec);
`endif
    @(negedge clk);
    check("done_one_cycle", o_done, 1'b0);
`ifdef QEA_JOB_LOADER_CYCLE_CNT_EN
    repeat (3) @(negedge clk);
    check("exec_cycles_held", o_exec_cycles, exp_exec);
`endif
    if (exp_exec < 0) $display("exec %0d", exp_exec);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int g;
    rst                = 1'b1;
    i_complete         = 1'b0;
    bus.i_cfg_valid    = 1'b0;
    bus.i_cfg_qbit_num = 6'd0;
    bus.i_cfg_ins_num  = 16'd0;
    bus.i_ctx_valid    = 1'b0;
    bus.i_ctx_data     = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Continuous beats, completion on the 50th WAIT cycle.
    load_job(11, 1971, 512, 1'b0, ok);
    if (ok) finish_job(11, 50, 1'b0);

    // Gapped beats; i_complete still high from the previous job.
    load_job(11, 1971, 512, 1'b1, ok);
    if (ok) finish_job(11, 0, 1'b1);
    i_complete = 1'b0;

    bad_header(11, 0);
    bad_header(2, 5);
    bad_header(20, 5);

    // Reset while the state image is being written.
    load_job(11, 3, 512, 1'b0, ok);
    g = 0;
    while (!(o_state_ena && o_state_addra == 16'd100) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("abort_point_reached", o_state_addra, 16'd100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    st_q.delete();
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;

    load_job(4, 3, 4, 1'b0, ok);
    if (ok) finish_job(4, 5, 1'b0);

    repeat (4) @(negedge clk);
    check("ctx_queue_empty", ctx_q.size(), 0);
    check("state_queue_empty", st_q.size(), 0);
    check("err_queue_empty", err_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
